ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: byte base address of the 16 KiB on-chip RAM window.
REQ-002 Parameter RST_PRIO, default 1: index of the port that wins the first two-way contention after reset.
REQ-003 clk_i  in  1  sole clock; all state on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 req_i  in  [1:0]  per-port access request; port 0 = instruction fetch, port 1 = data.
REQ-006 we_i  in  [1:0]  per-port write enable, qualified by req_i.
REQ-007 adr_i  in  [1:0][31:0]  per-port byte address.
REQ-008 be_i  in  [1:0][3:0]  per-port byte enables.
REQ-009 dat_i  in  [1:0][31:0]  per-port write data.
REQ-010 gnt_o  out  [1:0]  one-hot-or-zero grant; the access is issued to RAM in the same cycle.
REQ-011 rvalid_o  out  [1:0]  response strobe, exactly one cycle after that port's grant.
REQ-012 err_o  out  [1:0]  error flag, valid only with rvalid_o.
REQ-013 dat_o  out  32  shared read data, valid with any rvalid_o bit.
REQ-014 ram_we_o  out  1  RAM write enable.
REQ-015 ram_adr_o  out  12  RAM word address.
REQ-016 ram_be_o  out  4  RAM byte enables.
REQ-017 ram_dat_o  out  32  RAM write data.
REQ-018 ram_dat_i  in  32  RAM registered read data, valid one cycle after address.

Function
REQ-019 A requester holds req_i and its qualifiers stable until it sees gnt_o; the arbiter does not rely on any other requester behaviour.
REQ-020 Single request: the requesting port is granted combinationally in the same cycle.
REQ-021 Both requesting: grant the port not granted most recently (round-robin pointer, one flop, updated only on a grant).
REQ-022 Maximum wait for a requesting port is one cycle.
REQ-023 In-range check: adr_i[31:14] == BASE_ADDR[31:14]; adr_i[1:0] is ignored.
REQ-024 Granted in-range access: ram_adr_o = adr_i[13:2]; ram_be_o, ram_dat_o and ram_we_o = we_i of the granted port.
REQ-025 Granted out-of-range access: the grant still occurs, ram_we_o = 0, and the response carries err_o = 1 with dat_o = 0.
REQ-026 No grant: ram_we_o = 0; ram_adr_o, ram_be_o and ram_dat_o are don't-care but must not be X.
REQ-027 Response register, cleared by reset: pending owner (2-bit one-hot) and pending error, loaded each cycle from the grant.
REQ-028 rvalid_o equals the pending owner; err_o equals the pending owner ANDed with the pending error.
REQ-029 dat_o = ram_dat_i for in-range reads; 0 for writes and errors.
REQ-030 Back-to-back grants, including alternating ports, sustain one access per cycle with no bubble.
REQ-031 Read-after-write to the same word from either port returns the new data.
REQ-032 Write with be_i = 0 is granted and acknowledged, and no bytes change.

Reset
REQ-033 While rst_ni = 0: gnt_o = 0, rvalid_o = 0, err_o = 0, dat_o = 0, ram_we_o = 0, and the pointer = RST_PRIO.
REQ-034 Reset asserted mid-access: the pending response is discarded and no rvalid_o pulse follows deassertion.
REQ-035 First cycle after deassertion: normal arbitration.

Structure
REQ-036 Package ram_arb_pkg holds NPORTS = 2, RAM_AW = 12, the port index constants PORT_IFETCH = 0 and PORT_DATA = 1, and the default BASE_ADDR.
REQ-037 Sub-module ram_arb_rr_pick is a combinational two-way round-robin pick (inputs: req and pointer; output: one-hot grant); the pointer flop lives in the parent.

Verification
REQ-038 Port 1 writes 32'hDEADBEEF with be 4'hF to 32'h8000_0010, then port 0 reads the same address -> rvalid_o[0] one cycle after the read grant, dat_o = 32'hDEADBEEF.
REQ-039 Both ports request continuously right after reset (RST_PRIO = 1) -> grants go 1,0,1,0...; each port's rvalid_o trails its own grant by one cycle.
REQ-040 Write 32'h11223344 with be 4'b0100 to a word holding 0, then read it back -> 32'h00220000.
REQ-041 Port 0 reads 32'h0000_0040 -> granted, ram_we_o = 0, next cycle rvalid_o[0] = 1, err_o[0] = 1, dat_o = 0; the RAM word at index 16 is unchanged.
REQ-042 rst_ni pulled low the cycle after a port 1 grant -> no rvalid_o during reset or after deassertion; the pointer is back at 1.
REQ-043 Port 0 reads word 4095 (32'h8000_3FFC) -> correct data, no wrap to word 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and types for the RAM port arbiter
package ram_arb_pkg;

    localparam int unsigned NPORTS      = 2;
    localparam int unsigned RAM_AW      = 12;
    localparam int unsigned PORT_IFETCH = 0;
    localparam int unsigned PORT_DATA   = 1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    // Response bookkeeping for the access issued in the previous cycle
    typedef struct packed {
        logic [NPORTS-1:0] owner;
        logic              err;
        logic              rd;
    } resp_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side bus of the two-port RAM arbiter
interface ram_port_arbiter_if;
    import ram_arb_pkg::*;

    logic [NPORTS-1:0]       req_i;
    logic [NPORTS-1:0]       we_i;
    logic [NPORTS-1:0][31:0] adr_i;
    logic [NPORTS-1:0][3:0]  be_i;
    logic [NPORTS-1:0][31:0] dat_i;
    logic [NPORTS-1:0]       gnt_o;
    logic [NPORTS-1:0]       rvalid_o;
    logic [NPORTS-1:0]       err_o;
    logic [31:0]             dat_o;

    modport master (
        output req_i, we_i, adr_i, be_i, dat_i,
        input  gnt_o, rvalid_o, err_o, dat_o
    );

    modport slave (
        input  req_i, we_i, adr_i, be_i, dat_i,
        output gnt_o, rvalid_o, err_o, dat_o
    );
endinterface

// File: rtl/ram_arb_rr_pick.sv
// rtl/ram_arb_rr_pick.sv - combinational two-way round-robin pick
module ram_arb_rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              ptr,
    output logic [NPORTS-1:0] gnt
);

    // ptr names the port that wins when both are requesting
    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter of fetch and data ports onto one on-chip RAM
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned RST_PRIO  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ram_port_arbiter_if.slave bus,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    logic              ptr;
    logic [NPORTS-1:0] pick;
    logic [NPORTS-1:0] gnt;
    logic              any_gnt;
    logic              sel;
    logic              in_range;
    resp_t             pend;

    ram_arb_rr_pick u_pick (
        .req (bus.req_i),
        .ptr (ptr),
        .gnt (pick)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM
    assign gnt       = rst_ni ? pick : '0;
    assign any_gnt   = |gnt;
    assign sel       = gnt[PORT_DATA];
    assign in_range  = bus.adr_i[sel][31:14] == BASE_ADDR[31:14];
    assign bus.gnt_o = gnt;

    always_comb begin
        ram_we_o  = 1'b0;
        ram_adr_o = '0;
        ram_be_o  = '0;
        ram_dat_o = '0;
        if (any_gnt) begin
            ram_we_o  = bus.we_i[sel] & in_range;
            ram_adr_o = bus.adr_i[sel][13:2];
            ram_be_o  = bus.be_i[sel];
            ram_dat_o = bus.dat_i[sel];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= 1'(RST_PRIO);
        end else if (any_gnt) begin
            ptr <= ~sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend <= '0;
        end else begin
            pend.owner <= gnt;
            pend.err   <= any_gnt & ~in_range;
            pend.rd    <= any_gnt & in_range & ~bus.we_i[sel];
        end
    end

    assign bus.rvalid_o = pend.owner;
    assign bus.err_o    = pend.owner & {NPORTS{pend.err}};
    assign bus.dat_o    = pend.rd ? ram_dat_i : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_we;
    logic [11:0] ram_adr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat;
    logic [31:0] mem [4096];

    rsp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    ram_port_arbiter_if bus ();

    ram_port_arbiter #(
        .BASE_ADDR (32'h8000_0000),
        .RST_PRIO  (1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .ram_we_o  (ram_we),
        .ram_adr_o (ram_adr),
        .ram_be_o  (ram_be),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_adr][b*8 +: 8] <= ram_wdat[b*8 +: 8];
        end
        ram_rdat <= mem[ram_adr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation
    always begin
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (bus.rvalid_o[p]) begin
                if (q.size() == 0) begin
                    check($sformatf("unexpected_rvalid%0d", p), 32'(bus.rvalid_o), 32'h0);
                end else begin
                    rsp_t r;
                    r = q.pop_front();
                    check("rsp_port", 32'(p), 32'(r.port));
                    check("rsp_err", 32'(bus.err_o[p]), 32'(r.err));
                    check("rsp_dat", bus.dat_o, r.dat);
                end
            end
        end
    end

    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        bit got = 0;
        @(negedge clk);
        bus.req_i[p] = 1'b1;
        bus.we_i[p]  = w;
        bus.adr_i[p] = a;
        bus.be_i[p]  = b;
        bus.dat_i[p] = d;
        for (int c = 0; c < 4 && !got; c++) begin
            #2;
            if (bus.gnt_o[p]) begin
                got = 1;
                q.push_back('{port: p, err: exp_e, dat: exp_d});
                check("ram_we", 32'(ram_we), 32'(w & ~exp_e));
                if (!exp_e) check("ram_adr", 32'(ram_adr), 32'(a[13:2]));
            end
            @(negedge clk);
        end
        check("gnt_seen", 32'(got), 32'h1);
        bus.req_i[p] = 1'b0;
        check("rsp_latency", 32'(q.size()), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst_n     = 1'b0;
        bus.req_i = 2'b11;
        bus.we_i  = 2'b11;
        bus.adr_i = {32'h8000_0010, 32'h8000_0010};
        bus.be_i  = {4'hF, 4'hF};
        bus.dat_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt_o), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);
        check("rst_dat", bus.dat_o, 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        bus.req_i = 2'b00;
        rst_n = 1'b1;

        access(1, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(1, 1'b0, 32'h8000_0013, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b1, 32'h8000_0020, 4'b0100, 32'h1122_3344, 32'h0, 1'b0);
        access(1, 1'b0, 32'h8000_0020, 4'h0, 32'h0, 32'h0022_0000, 1'b0);
        access(1, 1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        access(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0, 1'b1);
        access(1, 1'b1, 32'h0000_0040, 4'hF, 32'h0000_0055, 32'h0, 1'b1);
        access(0, 1'b0, 32'h8000_0040, 4'h0, 32'h0, 32'h0, 1'b0);
        access(1, 1'b1, 32'h8000_3FFC, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0);
        access(0, 1'b0, 32'h8000_3FFC, 4'h0, 32'h0, 32'hA5A5_5A5A, 1'b0);
        access(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'h0, 1'b0);

        // Continuous contention right after reset: grants alternate starting at port 1
        do_reset();
        bus.we_i  = 2'b00;
        bus.adr_i = {32'h8000_0010, 32'h8000_0020};
        bus.req_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            #2;
            check($sformatf("rr_gnt%0d", i), 32'(bus.gnt_o), 32'(exp_g));
            if (exp_g[1]) q.push_back('{port: 1, err: 1'b0, dat: 32'hDEAD_BEEF});
            else          q.push_back('{port: 0, err: 1'b0, dat: 32'h0022_0000});
            @(negedge clk);
        end
        bus.req_i = 2'b00;
        @(negedge clk);
        check("rr_drain", 32'(q.size()), 32'h0);

        // Reset right at the edge that takes a port 1 grant: its response must vanish
        bus.req_i = 2'b10;
        #2;
        check("pre_rst_gnt", 32'(bus.gnt_o), 32'h2);
        @(posedge clk);
        rst_n     = 1'b0;
        bus.req_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("in_rst_rvalid%0d", i), 32'(bus.rvalid_o), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        bus.req_i = 2'b11;
        #2;
        check("post_rst_ptr", 32'(bus.gnt_o), 32'h2);
        if (bus.gnt_o[1]) q.push_back('{port: 1, err: 1'b0, dat: 32'hDEAD_BEEF});
        @(negedge clk);
        bus.req_i = 2'b00;

        repeat (3) @(negedge clk);
        check("final_drain", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
